// File: rtl/recfifo.sv
// Receive message FIFO between the LLC stage and the CPU interface: show-ahead frame
// buffer with sticky overflow. Optional watermark/overflow interrupt under RECFIFO_IRQ_EN.
module recfifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          activrreg,
    input  logic [28:0]   idrec,
    input  logic          extended,
    input  logic [3:0]    dlcrec,
    input  logic [63:0]   datarec,
    input  logic          rdreq,
    input  logic          ovclr,
`ifdef RECFIFO_IRQ_EN
    input  logic          rxirqen,
    input  logic [AW:0]   rxthresh,
    output logic          rxirq,
`endif
    output logic [28:0]   rdid,
    output logic          rdext,
    output logic [3:0]    rddlc,
    output logic [63:0]   rddata,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam int EW = 98;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] head;

    logic          act_q, act_d;
    logic [AW-1:0] wrptr_q, wrptr_d;
    logic [AW-1:0] rdptr_q, rdptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;

    logic push, pop, wr_en, ovf_evt;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign overflow = overflow_q;

    always_comb begin
        push    = activrreg & ~act_q;
        pop     = rdreq & ~empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        wr_en   = push & (~full | pop);
        ovf_evt = push & full & ~pop;

        act_d   = activrreg;
        wrptr_d = wr_en ? wrptr_q + 1'b1 : wrptr_q;
        rdptr_d = pop ? rdptr_q + 1'b1 : rdptr_q;
        count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

        overflow_d = overflow_q;
        if (ovclr)   overflow_d = 1'b0;
        if (ovf_evt) overflow_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            act_q      <= 1'b0;
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            act_q      <= act_d;
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; empty gating hides stale contents.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wrptr_q] <= {idrec, extended, dlcrec, datarec};
    end

    always_comb begin
        head   = empty ? '0 : mem_q[rdptr_q];
        rdid   = head[97:69];
        rdext  = head[68];
        rddlc  = head[67:64];
        rddata = head[63:0];
    end

`ifdef RECFIFO_IRQ_EN
    logic rxirq_q, rxirq_d;

    always_comb begin
        rxirq_d = rxirqen &
                  (((rxthresh != '0) && (count_d >= rxthresh)) || (overflow_d & ~overflow_q));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rxirq_q <= 1'b0;
        else        rxirq_q <= rxirq_d;
    end

    assign rxirq = rxirq_q;
`endif

endmodule

// File: doc/recfifo.md
Name: recfifo

Overview:
- Receive message FIFO directly downstream of the logic-link-control stage.
- Captures each accepted received frame (ID, extended flag, DLC, data) when the LLC raises its reception-register write enable. Buffers up to DEPTH frames for the CPU interface.
- Pops on CPU read request and maintains sticky overflow and status flags for the IOCPU register map.

Parameters:
DEPTH, 4, number of frame entries; power of two, 2..16
AW, 2, pointer width = log2(DEPTH)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
activrreg  input  1  LLC write enable for reception register; push request
idrec  input  29  received identifier from MAC (standard ID in [28:18])
extended  input  1  received frame was extended-format
dlcrec  input  4  received data length code
datarec  input  64  received data bytes, byte 0 in [63:56]
rdreq  input  1  CPU pop request (one entry per cycle high)
ovclr  input  1  CPU clear of sticky overflow flag
rdid  output  29  head entry identifier
rdext  output  1  head entry extended flag
rddlc  output  4  head entry DLC
rddata  output  64  head entry data
empty  output  1  FIFO holds no entry
full  output  1  FIFO holds DEPTH entries
count  output  AW+1  number of valid entries
overflow  output  1  sticky: a frame was dropped because FIFO full

Behaviour:
- Reset (reset low, asynchronous): wrptr=rdptr=0, count=0, empty=1, full=0, overflow=0, edge register=0. rdid/rdext/rddlc/rddata read 0 while empty. Storage array contents are not reset.
- Push detection:
  - activrreg is registered each cycle (act_q).
  - push = activrreg & ~act_q, i.e. one push per rising edge, even if the LLC holds activrreg for several cycles.
- Push, not full:
  - Entry {idrec, extended, dlcrec, datarec} is written at mem[wrptr] on the same clock edge where push is seen.
  - wrptr increments modulo DEPTH.
  - empty deasserts and count updates after that edge (1-cycle latency, input to visible).
- Pop:
  - When rdreq=1 and empty=0, rdptr increments modulo DEPTH at the edge.
  - Outputs are show-ahead: combinational from mem[rdptr], valid whenever empty=0.
  - rdreq while empty is ignored; no pointer change and no error flag.
- Simultaneous push and pop, not empty: both are performed. count is unchanged and the head advances.
- Simultaneous push and pop while full: the pop frees a slot and the push is accepted. overflow is not set and count stays DEPTH.
- Push while full without pop: the new frame is discarded and stored entries stay intact. overflow is set at that edge.
- Push while empty with rdreq=1: rdreq is ignored because empty=0 is not yet visible. The frame is stored.
- overflow is sticky:
  - It clears only on ovclr=1 or reset.
  - If ovclr and a new overflow event occur in the same cycle, the set wins (overflow=1).
- Flags:
  - count is a registered up/down counter, 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
  - Pointers wrap naturally at DEPTH with no gap entry.
- Reset mid-operation: all entries are lost and flags return to reset values immediately (asynchronous).
- DLC values 9..15 are stored unmodified; clipping to 8 bytes is the CPU's responsibility.

Optional Feature:
- Macro: RECFIFO_IRQ_EN.
- When defined, the block adds:
  - input rxirqen (1): enable.
  - input [AW:0] rxthresh: watermark.
  - output rxirq (1): registered, resets to 0.
- rxirq=1 in the cycle after the edge where:
  - count >= rxthresh with rxthresh != 0 and rxirqen=1, or
  - overflow becomes 1 with rxirqen=1.
- rxirq drops the cycle after the condition is gone.
- When not defined, none of these ports exist and there is no additional logic. All other behaviour is identical.

Test Plan:
- Reset, then a single activrreg pulse with idrec=29'h12345678 masked to 29 bits, extended=1, dlcrec=8, datarec=64'h0102030405060708:
  - next cycle empty=0, count=1, rdid/rdext/rddlc/rddata show these values.
  - rdreq pulse gives empty=1, count=0.
- activrreg held high for 5 cycles -> exactly one entry stored, count=1.
- DEPTH=4: push IDs 1,2,3,4 -> full=1, count=4. Push ID 5 -> overflow=1, count=4, and pops return 1,2,3,4 in order, then empty=1.
- Full FIFO with push and rdreq in the same cycle -> head advances to ID 2, new ID stored at tail, count=4, overflow stays 0. Then ovclr together with a new overflowing push leaves overflow=1.
- Wrap-around: 10 push/pop pairs interleaved (IDs 0..9) -> every pop returns IDs in order, count never exceeds 1, pointers wrap with no corruption.
- With RECFIFO_IRQ_EN defined, rxirqen=1 and rxthresh=2: the first push leaves rxirq=0, the second push gives rxirq=1 the next cycle, and one pop returns rxirq=0.
- Asserting reset mid-burst drops all flags and count to 0 asynchronously.
